// File: rtl/apple1_pkg.sv
// Shared Apple-1 system definitions: RAM geometry and arbiter owner encoding.
package apple1_pkg;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    localparam int RAM_ADDR_W   = 13;
    localparam int RAM_DATA_W   = 8;
    localparam int ARB_MAX_WAIT = 7;

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester port of the system RAM arbiter: request/grant handshake plus tagged read return.
interface ram_arbiter_if
    import apple1_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, addr, we, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Shares the single-port synchronous RAM between the CPU (port A, fixed priority) and a DMA
// master (port B, forced ahead after MAX_WAIT refusals); reads return two cycles after grant.
module ram_arbiter
    import apple1_pkg::*;
#(
    parameter int ADDR_W   = RAM_ADDR_W,
    parameter int DATA_W   = RAM_DATA_W,
    parameter int MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset_n,
    ram_arbiter_if.slave      port_a,
    ram_arbiter_if.slave      port_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);
    localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              force_b, a_gnt, b_gnt, acc;
    owner_e            own_sel;
    logic [ADDR_W-1:0] addr_sel, mem_addr_q, mem_addr_d;
    logic              we_sel, mem_we_q, mem_we_d;
    logic [DATA_W-1:0] wdata_sel, mem_din_q, mem_din_d;
    logic              vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
    owner_e            own_p0_q, own_p0_d, own_p1_q, own_p1_d;

    assign force_b = (wait_cnt_q == CNT_MAX);

    // Grant: A has priority unless B has been refused MAX_WAIT cycles in a row.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (reset_n) begin
            if (force_b) begin
                b_gnt = port_b.req;
                a_gnt = port_a.req & ~port_b.req;
            end else begin
                a_gnt = port_a.req;
                b_gnt = port_b.req & ~port_a.req;
            end
        end
    end

    // Stage p0: accepted access registered toward the RAM, read tag enters pipeline
    always_comb begin
        acc        = a_gnt | b_gnt;
        own_sel    = b_gnt ? OWN_B : OWN_A;
        addr_sel   = b_gnt ? port_b.addr : port_a.addr;
        we_sel     = b_gnt ? port_b.we : port_a.we;
        wdata_sel  = b_gnt ? port_b.wdata : port_a.wdata;

        mem_addr_d = acc ? addr_sel : mem_addr_q;
        mem_we_d   = acc & we_sel;
        mem_din_d  = acc ? wdata_sel : mem_din_q;

        wait_cnt_d = wait_cnt_q;
        if (!port_b.req || b_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end

        vld_p0_d = acc & ~we_sel;
        own_p0_d = own_sel;
        // Stage p1: tag lines up with mem_dout for the access driven in p0
        vld_p1_d = vld_p0_q;
        own_p1_d = own_p0_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= '0;
            vld_p0_q   <= 1'b0;
            vld_p1_q   <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_din_q  <= mem_din_d;
            vld_p0_q   <= vld_p0_d;
            vld_p1_q   <= vld_p1_d;
        end
    end

    always_ff @(posedge clk) begin
        own_p0_q <= own_p0_d;
        own_p1_q <= own_p1_d;
    end

    assign mem_addr      = mem_addr_q;
    assign mem_we        = mem_we_q;
    assign mem_din       = mem_din_q;

    assign port_a.gnt    = a_gnt;
    assign port_b.gnt    = b_gnt;
    assign port_a.rvalid = vld_p1_q & (own_p1_q == OWN_A);
    assign port_b.rvalid = vld_p1_q & (own_p1_q == OWN_B);
    assign port_a.rdata  = mem_dout;
    assign port_b.rdata  = mem_dout;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter sharing the single-port, synchronous-read system RAM (8 KiB at 0x0000–0x1FFF) between the 6502 bus (port A) and a secondary DMA master (port B: video/terminal scanner or serial loader). It sits between the CPU bus registers and the RAM instance. Port A has fixed priority. Port B takes every cycle A leaves free, plus a forced slot after a bounded wait. Read data returns on a fixed-latency pipeline tagged by owner.

## Interface
Parameters:
- ADDR_W, 13, RAM word address width
- DATA_W, 8, data width
- MAX_WAIT, 7, cycles port B may be refused before it is forced ahead of A (1..255)

Ports:
- clk  in  1  system clock (25 MHz domain)
- reset_n  in  1  synchronous, active-low reset
- a_req  in  1  port A access request; held with stable a_addr/a_we/a_wdata until a_gnt
- a_addr  in  ADDR_W  port A address
- a_we  in  1  port A write enable (1 = write)
- a_wdata  in  DATA_W  port A write data
- a_gnt  out  1  port A request accepted this cycle (combinational)
- a_rvalid  out  1  port A read data valid
- a_rdata  out  DATA_W  port A read data
- b_req, b_addr, b_we, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for port B
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_din  out  DATA_W  RAM write data (registered)
- mem_dout  in  DATA_W  RAM read data, valid one cycle after mem_addr

## Operation
- Grant decision each cycle, combinational from req inputs and the `force_b` flag:
  - force_b=0: a_req wins; else b_req.
  - force_b=1: b_req wins; else a_req.
  - At most one gnt per cycle. No gnt without req.
- Accepted access (cycle t) is registered into mem_addr/mem_we/mem_din, driven in t+1.
- Idle cycles: mem_we=0; mem_addr and mem_din hold their last values.
- Wait counter (width clog2(MAX_WAIT+1)):
  - Increments each cycle b_req=1 and b_gnt=0.
  - Clears on b_gnt or b_req=0.
  - Saturates at MAX_WAIT.
  - force_b = (wait_cnt == MAX_WAIT).
- Read pipeline: 2-stage shift of {valid, owner}.
  - Stage 0 loads {gnt & ~we, owner} at accept.
  - Stage 1 is sampled with mem_dout.
  - x_rvalid = stage1.valid & (stage1.owner == x).
  - a_rdata and b_rdata are both driven from mem_dout; only the valid owner's rvalid asserts.
- Writes produce no rvalid.
- Read immediately after write to the same address returns the new data; the RAM is write-first.
- Reset (reset_n=0 at a rising edge):
  - pipeline valids cleared, so in-flight reads never produce rvalid;
  - wait_cnt=0, mem_we=0, mem_addr=0, mem_din=0.
  - gnt outputs forced 0 while reset_n=0.

## Timing
- Read latency: accept at cycle t, then mem_addr driven at t+1, then x_rvalid/x_rdata at t+2.
- Write: accept at t, mem_we=1 at t+1, data in RAM after the t+1 edge.
- Throughput: one access per cycle, any mix of owners. Back-to-back grants are fully pipelined.
- Worst-case B wait: MAX_WAIT cycles of refusal, then granted at the next cycle.
- Worst-case A delay caused by forcing: 1 cycle per MAX_WAIT+1 cycles. The CPU slot (cpu_clken period ≥ 4) absorbs it.
- Reset values of all outputs: 0.

## Structure
- Shared package `apple1_pkg`:
  - owner encoding OWN_A=1'b0, OWN_B=1'b1;
  - RAM_ADDR_W=13;
  - default MAX_WAIT.
- The pipeline is small enough to stay inline.
- Optional sub-module `arb_wait_counter`: saturating counter with clear, exposing `force_b`.

## Test plan
- Single A read of 0x0123 (RAM preloaded 0x5A): a_gnt same cycle, a_rvalid=1 with a_rdata=0x5A exactly 2 cycles later; b_rvalid stays 0.
- A write 0x1FFF←0xC3 then A read 0x1FFF on the next cycle: both granted back-to-back; read returns 0xC3 at t+3.
- Simultaneous a_req and b_req (reads 0x0010/0x0020), A held continuously: A granted 7 consecutive cycles, then B granted on the 8th (MAX_WAIT=7); b_rdata correct with b_rvalid; wait counter cleared afterwards.
- Alternating A/B reads every cycle, 16 cycles: rvalid owner sequence matches grant sequence shifted 2 cycles; no cycle has both rvalids set.
- reset_n low for 1 cycle while two reads are in flight: no rvalid in the following 3 cycles; mem_we=0; first post-reset request granted normally.
- Idle bus (no req) for 10 cycles: mem_we stays 0, no gnt, no rvalid, wait_cnt stays 0.
